jt49_wrsched: RTL and testbench

Write scheduler that sits in front of the JT49 BDIR/BC1 bus wrapper and turns register-write requests from two independent requesters (port A, port B) into legal PSG bus cycles. Requests are round-robin arbitrated into a small FIFO. A bus FSM drains the FIFO as address-latch / write-data sequences on bdir/bc1/bus_dout. The block lets a CPU and a hardware music player share one PSG without software locking.

---
 rtl/jt49_wrsched.sv | 186 ++++++++++++++++++
 tb/tb_jt49_wrsched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_wrsched.sv
// jt49_wrsched
// Write scheduler in front of the JT49 BDIR/BC1 bus wrapper. Two independent
// requesters (A, B) post register writes. The writes are round-robin arbitrated
// into a FIFO and replayed on the PSG bus as address-latch / write-data cycles.
//
// Ports
//   clk, rst_n              system clock, synchronous active-low reset
//   a_req/a_addr/a_data     port A write request (payload stable while a_req=1)
//   a_ack                   one-cycle pulse, port A entry accepted
//   b_req/b_addr/b_data     port B write request
//   b_ack                   one-cycle pulse, port B entry accepted
//   bdir, bc1, bus_dout     PSG bus outputs (registered)
//   busy                    FIFO non-empty or bus FSM active
//   full                    FIFO holds DEPTH entries
//   level                   FIFO occupancy, 0..DEPTH
module jt49_wrsched #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_req,
    input  logic [3:0]               a_addr,
    input  logic [7:0]               a_data,
    output logic                     a_ack,
    input  logic                     b_req,
    input  logic [3:0]               b_addr,
    input  logic [7:0]               b_data,
    output logic                     b_ack,
    output logic                     bdir,
    output logic                     bc1,
    output logic [7:0]               bus_dout,
    output logic                     busy,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [PW:0]   DEPTH_L   = (PW+1)'(DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LATCH = 3'd1;
    localparam logic [2:0] ST_GAP1  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_GAP2  = 3'd4;

    logic [11:0]    mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;
    logic [11:0]    head;
    logic           empty;
    logic           pop;
    logic           room;
    logic           a_elig;
    logic           b_elig;
    logic           grant_a;
    logic           grant_b;
    logic           push;
    logic [11:0]    push_word;
    logic           prio_b;
    logic [2:0]     state;
    logic [CW-1:0]  hold_cnt;
    logic [7:0]     work_data;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == DEPTH_L);
    assign level = count;
    assign busy  = !empty || (state != ST_IDLE);

    // The FSM only pops when it is about to start a new bus write.
    assign pop = !empty && ((state == ST_IDLE) || (state == ST_GAP2));

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign room   = !full || pop;
    assign a_elig = a_req && !a_ack && room;
    assign b_elig = b_req && !b_ack && room;

    // prio_b set means B was not granted last and wins a tie.
    assign grant_a   = a_elig && (!b_elig || !prio_b);
    assign grant_b   = b_elig && (!a_elig ||  prio_b);
    assign push      = grant_a || grant_b;
    assign push_word = grant_a ? {a_addr, a_data} : {b_addr, b_data};

    // Arbiter and FIFO control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_ack  <= 1'b0;
            b_ack  <= 1'b0;
            prio_b <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            a_ack <= grant_a;
            b_ack <= grant_b;
            if (grant_a) begin
                prio_b <= 1'b1;
            end else if (grant_b) begin
                prio_b <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage and the popped data byte carry no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
        if (pop) begin
            work_data <= head[7:0];
        end
    end

    // Bus FSM: LATCH(HOLD) -> GAP1 -> WRITE(HOLD) -> GAP2, outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            bdir     <= 1'b0;
            bc1      <= 1'b0;
            bus_dout <= 8'h00;
        end else begin
            case (state)
                ST_IDLE, ST_GAP2: begin
                    if (!empty) begin
                        state    <= ST_LATCH;
                        hold_cnt <= '0;
                        bdir     <= 1'b1;
                        bc1      <= 1'b1;
                        bus_dout <= {4'h0, head[11:8]};
                    end else begin
                        state    <= ST_IDLE;
                        bdir     <= 1'b0;
                        bc1      <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= ST_GAP1;
                        bdir  <= 1'b0;
                        bc1   <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_GAP1: begin
                    state    <= ST_WRITE;
                    hold_cnt <= '0;
                    bdir     <= 1'b1;
                    bc1      <= 1'b0;
                    bus_dout <= work_data;
                end
                ST_WRITE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= ST_GAP2;
                        bdir  <= 1'b0;
                        bc1   <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    bdir  <= 1'b0;
                    bc1   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt49_wrsched.sv
// tb_jt49_wrsched
// Directed bench for jt49_wrsched. u0 runs with HOLD=2, u1 with HOLD=1; both
// share clock and reset. A negedge monitor records bus writes per instance
// and flags any direct 11->10 transition on {bdir,bc1}.
module tb_jt49_wrsched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_req = 1'b0, b_req = 1'b0;
    logic [3:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ack, b_ack, bdir, bc1, busy, full;
    logic [7:0] bus_dout;
    logic [2:0] level;

    logic       a_req_h1 = 1'b0, b_req_h1 = 1'b0;
    logic [3:0] a_addr_h1 = '0, b_addr_h1 = '0;
    logic [7:0] a_data_h1 = '0, b_data_h1 = '0;
    logic       a_ack_h1, b_ack_h1, bdir_h1, bc1_h1, busy_h1, full_h1;
    logic [7:0] bus_dout_h1;
    logic [2:0] level_h1;

    int checks = 0;
    int errors = 0;

    jt49_wrsched #(.DEPTH(4), .HOLD(2)) u0 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
        .bdir(bdir), .bc1(bc1), .bus_dout(bus_dout),
        .busy(busy), .full(full), .level(level)
    );

    jt49_wrsched #(.DEPTH(4), .HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req_h1), .a_addr(a_addr_h1), .a_data(a_data_h1), .a_ack(a_ack_h1),
        .b_req(b_req_h1), .b_addr(b_addr_h1), .b_data(b_data_h1), .b_ack(b_ack_h1),
        .bdir(bdir_h1), .bc1(bc1_h1), .bus_dout(bus_dout_h1),
        .busy(busy_h1), .full(full_h1), .level(level_h1)
    );

    always #5 clk = ~clk;

    // Bus monitor
    logic [1:0]  prev0 = 2'b00, prev1 = 2'b00;
    logic [3:0]  lat0 = '0, lat1 = '0;
    logic [11:0] cap0[$];
    logic [11:0] cap1[$];

    always @(negedge clk) begin
        if (prev0 == 2'b11) begin
            checks++;
            if ({bdir, bc1} == 2'b10) begin
                errors++;
                $display("FAIL gap_u0: {bdir,bc1} went 11 -> %b, required 00 gap", {bdir, bc1});
            end
        end
        if (prev1 == 2'b11) begin
            checks++;
            if ({bdir_h1, bc1_h1} == 2'b10) begin
                errors++;
                $display("FAIL gap_u1: {bdir,bc1} went 11 -> %b, required 00 gap", {bdir_h1, bc1_h1});
            end
        end
        if ({bdir, bc1} == 2'b11 && prev0 != 2'b11) lat0 = bus_dout[3:0];
        if ({bdir, bc1} == 2'b10 && prev0 != 2'b10) cap0.push_back({lat0, bus_dout});
        if ({bdir_h1, bc1_h1} == 2'b11 && prev1 != 2'b11) lat1 = bus_dout_h1[3:0];
        if ({bdir_h1, bc1_h1} == 2'b10 && prev1 != 2'b10) cap1.push_back({lat1, bus_dout_h1});
        prev0 = {bdir, bc1};
        prev1 = {bdir_h1, bc1_h1};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0; a_req_h1 = 1'b0; b_req_h1 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({a_ack, b_ack} !== 2'b00) begin
            errors++; $display("FAIL reset_ack: got %b required 00", {a_ack, b_ack});
        end
        checks++;
        if ({bdir, bc1} !== 2'b00) begin
            errors++; $display("FAIL reset_bus: got %b required 00", {bdir, bc1});
        end
        checks++;
        if (bus_dout !== 8'h00) begin
            errors++; $display("FAIL reset_dout: got %h required 00", bus_dout);
        end
        checks++;
        if ({busy, full, level} !== 5'b0) begin
            errors++; $display("FAIL reset_status: busy=%b full=%b level=%0d required 0/0/0", busy, full, level);
        end
        checks++;
        if ({busy_h1, full_h1, level_h1, bdir_h1, bc1_h1} !== 7'b0) begin
            errors++; $display("FAIL reset_u1: busy=%b level=%0d bus=%b required 0/0/00", busy_h1, level_h1, {bdir_h1, bc1_h1});
        end
    endtask

    task automatic test_single;
        logic [1:0] eb [7];
        logic [7:0] ed [7];
        logic       ey [7];
        eb = '{2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
        ed = '{8'h07, 8'h07, 8'h07, 8'h38, 8'h38, 8'h38, 8'h38};
        ey = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        a_req = 1'b1; a_addr = 4'd7; a_data = 8'h38;
        tick();
        checks++;
        if ({a_ack, level, busy, bdir, bc1} !== {1'b1, 3'd1, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL single_ack: ack=%b level=%0d busy=%b bus=%b required 1/1/1/00", a_ack, level, busy, {bdir, bc1});
        end
        a_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if ({bdir, bc1} !== eb[i] || bus_dout !== ed[i] || busy !== ey[i]) begin
                errors++;
                $display("FAIL single_seq[%0d]: bus=%b dout=%h busy=%b required %b/%h/%b", i, {bdir, bc1}, bus_dout, busy, eb[i], ed[i], ey[i]);
            end
        end
        checks++;
        if (a_ack !== 1'b0) begin
            errors++; $display("FAIL single_ack_pulse: a_ack=%b required 0", a_ack);
        end
    endtask

    task automatic test_contention;
        logic [1:0] eb [13];
        logic [7:0] ed [13];
        eb = '{2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00,
               2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
        ed = '{8'h01, 8'h01, 8'h01, 8'h11, 8'h11, 8'h11,
               8'h02, 8'h02, 8'h02, 8'h22, 8'h22, 8'h22, 8'h22};
        do_reset();
        a_req = 1'b1; a_addr = 4'd1; a_data = 8'h11;
        b_req = 1'b1; b_addr = 4'd2; b_data = 8'h22;
        tick();
        checks++;
        if ({a_ack, b_ack, level} !== {1'b1, 1'b0, 3'd1}) begin
            errors++; $display("FAIL cont_first: a_ack=%b b_ack=%b level=%0d required 1/0/1", a_ack, b_ack, level);
        end
        a_req = 1'b0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if ({a_ack, b_ack, level} !== {1'b0, 1'b1, 3'd1}) begin
                    errors++; $display("FAIL cont_second: a_ack=%b b_ack=%b level=%0d required 0/1/1", a_ack, b_ack, level);
                end
                b_req = 1'b0;
            end
            checks++;
            if ({bdir, bc1} !== eb[i] || bus_dout !== ed[i] || busy !== (i != 12)) begin
                errors++;
                $display("FAIL cont_seq[%0d]: bus=%b dout=%h busy=%b required %b/%h/%b", i, {bdir, bc1}, bus_dout, busy, eb[i], ed[i], (i != 12));
            end
        end
    endtask

    task automatic test_overflow;
        int idx;
        logic [7:0] d;
        do_reset();
        cap0.delete();
        idx = 0;
        a_req = 1'b1; a_addr = 4'd0; a_data = 8'hA0;
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            tick();
            if (a_ack) begin
                idx++;
                if (idx < 6) begin
                    d = 8'hA0 + 8'(idx);
                    a_addr = idx[3:0]; a_data = d;
                end else begin
                    a_req = 1'b0;
                end
            end
        end
        checks++;
        if (idx != 6) begin
            errors++; $display("FAIL ovf_acks: got %0d acks required 6", idx);
        end
        checks++;
        if ({full, level} !== {1'b1, 3'd4}) begin
            errors++; $display("FAIL ovf_full: full=%b level=%0d required 1/4", full, level);
        end
    endtask

    // Continues from the full FIFO left by test_overflow.
    task automatic test_push_pop_full;
        logic [7:0] d;
        int cyc;
        b_req = 1'b1; b_addr = 4'hF; b_data = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (b_ack !== (k == 2) || level !== 3'd4 || full !== 1'b1) begin
                errors++;
                $display("FAIL pp_full[%0d]: b_ack=%b level=%0d full=%b required %b/4/1", k, b_ack, level, full, (k == 2));
            end
        end
        b_req = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL pp_drain: busy=%b after %0d cycles required 0", busy, cyc);
        end
        checks++;
        if (cap0.size() != 7) begin
            errors++; $display("FAIL pp_count: got %0d bus writes required 7", cap0.size());
        end
        for (int i = 0; i < 7 && i < cap0.size(); i++) begin
            d = 8'hA0 + 8'(i);
            checks++;
            if (i < 6 && cap0[i] !== {4'(i), d}) begin
                errors++; $display("FAIL pp_order[%0d]: got %h required %h", i, cap0[i], {4'(i), d});
            end else if (i == 6 && cap0[i] !== 12'hF5A) begin
                errors++; $display("FAIL pp_order[6]: got %h required f5a", cap0[i]);
            end
        end
    endtask

    task automatic test_reset_mid_write;
        int na, nb, act;
        do_reset();
        cap0.delete();
        na = 0; nb = 0;
        a_req = 1'b1; a_addr = 4'd1; a_data = 8'h11;
        b_req = 1'b1; b_addr = 4'd2; b_data = 8'h22;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (a_ack) begin
                na++;
                if (na == 2) a_req = 1'b0; else begin a_addr = 4'd3; a_data = 8'h33; end
            end
            if (b_ack) begin
                nb++;
                if (nb == 2) b_req = 1'b0; else begin b_addr = 4'd4; b_data = 8'h44; end
            end
            if ({bdir, bc1} == 2'b10) break;
        end
        checks++;
        if ({bdir, bc1, bus_dout, level} !== {2'b10, 8'h11, 3'd3}) begin
            errors++; $display("FAIL rst_pre: bus=%b dout=%h level=%0d required 10/11/3", {bdir, bc1}, bus_dout, level);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({bdir, bc1, bus_dout, level, busy, full, a_ack, b_ack} !== 16'b0) begin
            errors++;
            $display("FAIL rst_mid: bus=%b dout=%h level=%0d busy=%b full=%b acks=%b required all zero",
                     {bdir, bc1}, bus_dout, level, busy, full, {a_ack, b_ack});
        end
        act = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (bdir || bc1 || busy || level != 0) act++;
        end
        checks++;
        if (act != 0) begin
            errors++; $display("FAIL rst_quiet: %0d active cycles after reset required 0", act);
        end
        checks++;
        if (cap0.size() != 1) begin
            errors++; $display("FAIL rst_writes: got %0d bus writes required 1", cap0.size());
        end
    endtask

    task automatic test_hold1;
        logic [1:0] eb [8];
        logic [7:0] ed [8];
        eb = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00};
        ed = '{8'h03, 8'hC3, 8'hC3, 8'h05, 8'h05, 8'h5C, 8'h5C, 8'h5C};
        do_reset();
        cap1.delete();
        a_req_h1 = 1'b1; a_addr_h1 = 4'd3; a_data_h1 = 8'hC3;
        b_req_h1 = 1'b1; b_addr_h1 = 4'd5; b_data_h1 = 8'h5C;
        tick();
        checks++;
        if ({a_ack_h1, b_ack_h1} !== 2'b10) begin
            errors++; $display("FAIL h1_first: acks=%b required 10", {a_ack_h1, b_ack_h1});
        end
        a_req_h1 = 1'b0;
        tick();
        checks++;
        if ({b_ack_h1, bdir_h1, bc1_h1, bus_dout_h1} !== {1'b1, 2'b11, 8'h03}) begin
            errors++; $display("FAIL h1_latch: b_ack=%b bus=%b dout=%h required 1/11/03", b_ack_h1, {bdir_h1, bc1_h1}, bus_dout_h1);
        end
        b_req_h1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({bdir_h1, bc1_h1} !== eb[i] || bus_dout_h1 !== ed[i] || busy_h1 !== (i != 7)) begin
                errors++;
                $display("FAIL h1_seq[%0d]: bus=%b dout=%h busy=%b required %b/%h/%b", i, {bdir_h1, bc1_h1}, bus_dout_h1, busy_h1, eb[i], ed[i], (i != 7));
            end
        end
        checks++;
        if (cap1.size() != 2 || cap1[0] !== 12'h3C3 || cap1[1] !== 12'h55C) begin
            errors++; $display("FAIL h1_writes: got %0d writes required 3c3,55c", cap1.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_write();
        test_hold1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
